// File: rtl/grid_pkg.sv
// Shared defaults and types for the grid difference tracker.
// Holds the default grid geometry, the empty-cell code and the
// refresh-state enum used by grid_diff_tracker.
package grid_pkg;

    localparam int DEF_GRID_W  = 16;
    localparam int DEF_GRID_H  = 12;
    localparam int DEF_NUM_OBJ = 4;
    localparam int CODE_EMPTY  = 0;

    typedef enum logic [1:0] {
        RS_NORMAL  = 2'd0,
        RS_PEND    = 2'd1,
        RS_REFRESH = 2'd2
    } refresh_state_t;

endpackage

// File: rtl/obj_prio_enc.sv
// Object-hit priority encoder (combinational).
// Ports:
//   obj_hit [NUM_OBJ-1:0] in   per-object hit flags
//   code    [CODE_W-1:0]  out  0 when no hit, else index of highest set bit + 1
module obj_prio_enc #(
    parameter int NUM_OBJ = 4,
    parameter int CODE_W  = 3
) (
    input  logic [NUM_OBJ-1:0] obj_hit,
    output logic [CODE_W-1:0]  code
);

    // Later iterations overwrite earlier ones, so the highest index wins.
    always_comb begin
        code = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (obj_hit[i]) code = CODE_W'(i + 1);
        end
    end

endmodule

// File: rtl/grid_diff_tracker.sv
// Raster-scans a GRID_W x GRID_H grid, keeps the last code seen per cell
// and emits a valid/ready update record whenever a cell's code changes.
// A refresh request makes the next full pass (starting at (0,0)) report
// every cell regardless of change.
// Ports:
//   clk, nrst                       clock, async active-low reset
//   enable                          advance request for the current cell
//   obj_hit [NUM_OBJ]               hit flags for the cell at the cursor
//   refresh_req                     request a full-report pass
//   clear                           synchronous wipe of frame and cursor
//   cur_x, cur_y                    cursor position
//   upd_valid, upd_ready            update record handshake
//   upd_x, upd_y, upd_code          update record
//   frame_done                      pulse after the last cell is consumed
//   refresh_active                  current advance belongs to a refresh pass
//
// state      | meaning
// RS_NORMAL  | report changed cells only
// RS_PEND    | refresh requested, waiting for the cursor to reach (0,0)
// RS_REFRESH | report every cell until the last cell is consumed
module grid_diff_tracker
    import grid_pkg::*;
#(
    parameter int GRID_W  = DEF_GRID_W,
    parameter int GRID_H  = DEF_GRID_H,
    parameter int NUM_OBJ = DEF_NUM_OBJ,
    localparam int X_W    = $clog2(GRID_W),
    localparam int Y_W    = $clog2(GRID_H),
    localparam int CODE_W = $clog2(NUM_OBJ + 1)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               enable,
    input  logic [NUM_OBJ-1:0] obj_hit,
    input  logic               refresh_req,
    input  logic               clear,
    output logic [X_W-1:0]     cur_x,
    output logic [Y_W-1:0]     cur_y,
    output logic               upd_valid,
    input  logic               upd_ready,
    output logic [X_W-1:0]     upd_x,
    output logic [Y_W-1:0]     upd_y,
    output logic [CODE_W-1:0]  upd_code,
    output logic               frame_done,
    output logic               refresh_active
);

    logic [CODE_W-1:0] frame [GRID_H][GRID_W];
    logic [CODE_W-1:0] new_code;
    logic [CODE_W-1:0] stored_code;
    logic              stall;
    logic              advance;
    logic              x_last;
    logic              y_last;
    logic              at_origin;
    logic              load;
    refresh_state_t    state;

    obj_prio_enc #(
        .NUM_OBJ (NUM_OBJ),
        .CODE_W  (CODE_W)
    ) u_prio (
        .obj_hit (obj_hit),
        .code    (new_code)
    );

    assign stall       = upd_valid && !upd_ready;
    assign advance     = enable && !stall && !clear;
    assign x_last      = (cur_x == X_W'(GRID_W - 1));
    assign y_last      = (cur_y == Y_W'(GRID_H - 1));
    assign at_origin   = (cur_x == '0) && (cur_y == '0);
    assign stored_code = frame[cur_y][cur_x];

    // The (0,0) advance that leaves PEND already belongs to the refresh pass.
    assign refresh_active = (state == RS_REFRESH) ||
                            ((state == RS_PEND) && at_origin && advance);

    assign load = advance && ((new_code != stored_code) || refresh_active);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int y = 0; y < GRID_H; y++)
                for (int x = 0; x < GRID_W; x++)
                    frame[y][x] <= CODE_W'(CODE_EMPTY);
        end else if (clear) begin
            for (int y = 0; y < GRID_H; y++)
                for (int x = 0; x < GRID_W; x++)
                    frame[y][x] <= CODE_W'(CODE_EMPTY);
        end else if (advance) begin
            frame[cur_y][cur_x] <= new_code;
        end
    end

    // Compare-and-wrap keeps the cursor inside non-power-of-two grids.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cur_x      <= '0;
            cur_y      <= '0;
            frame_done <= 1'b0;
        end else if (clear) begin
            cur_x      <= '0;
            cur_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= advance && x_last && y_last;
            if (advance) begin
                if (x_last) begin
                    cur_x <= '0;
                    cur_y <= y_last ? '0 : cur_y + Y_W'(1);
                end else begin
                    cur_x <= cur_x + X_W'(1);
                end
            end
        end
    end

    // A new load takes priority over an accept, so back-to-back records
    // never leave a bubble.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            upd_valid <= 1'b0;
            upd_x     <= '0;
            upd_y     <= '0;
            upd_code  <= '0;
        end else if (clear) begin
            upd_valid <= 1'b0;
        end else if (load) begin
            upd_valid <= 1'b1;
            upd_x     <= cur_x;
            upd_y     <= cur_y;
            upd_code  <= new_code;
        end else if (upd_ready) begin
            upd_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= RS_NORMAL;
        end else if (clear) begin
            state <= RS_NORMAL;
        end else begin
            case (state)
                RS_NORMAL:  if (refresh_req) state <= RS_PEND;
                RS_PEND:    if (advance && at_origin) state <= RS_REFRESH;
                RS_REFRESH: if (advance && x_last && y_last) state <= RS_NORMAL;
                default:    state <= RS_NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_diff_tracker.sv
// Bench for grid_diff_tracker: a linear-index reference model of the
// 16x12 grid checked every cycle, plus a 5x3 / 7-object instance.
module tb_grid_diff_tracker;

    localparam int W = 16;
    localparam int H = 12;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       nrst;
    logic       enable, refresh_req, clear, upd_ready;
    logic [3:0] obj_hit;
    logic [3:0] cur_x, upd_x;
    logic [3:0] cur_y, upd_y;
    logic [2:0] upd_code;
    logic       upd_valid, frame_done, refresh_active;

    logic       enable2, refresh_req2, clear2, upd_ready2;
    logic [6:0] obj_hit2;
    logic [2:0] cur_x2, upd_x2;
    logic [1:0] cur_y2, upd_y2;
    logic [2:0] upd_code2;
    logic       upd_valid2, frame_done2, refresh_active2;

    always #5 clk = ~clk;

    grid_diff_tracker dut (
        .clk(clk), .nrst(nrst), .enable(enable), .obj_hit(obj_hit),
        .refresh_req(refresh_req), .clear(clear), .cur_x(cur_x), .cur_y(cur_y),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_x(upd_x), .upd_y(upd_y),
        .upd_code(upd_code), .frame_done(frame_done), .refresh_active(refresh_active)
    );

    grid_diff_tracker #(.GRID_W(5), .GRID_H(3), .NUM_OBJ(7)) dut2 (
        .clk(clk), .nrst(nrst), .enable(enable2), .obj_hit(obj_hit2),
        .refresh_req(refresh_req2), .clear(clear2), .cur_x(cur_x2), .cur_y(cur_y2),
        .upd_valid(upd_valid2), .upd_ready(upd_ready2), .upd_x(upd_x2), .upd_y(upd_y2),
        .upd_code(upd_code2), .frame_done(frame_done2), .refresh_active(refresh_active2)
    );

    int total = 0;
    int bad   = 0;

    // reference model: cell index p = y*W + x, mode 0 normal / 1 pending / 2 refresh
    int m_frame [N];
    int m_pos, m_mode, m_rx, m_ry, m_rc;
    bit m_valid, m_done;
    int pat [N];
    int xfers, fdones, lx, ly, lc;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_frame[i] = 0;
        m_pos = 0; m_mode = 0; m_valid = 0; m_done = 0;
    endtask

    // Drives one cycle of inputs, advances the model, checks after the edge.
    task automatic step(input bit en, input logic [3:0] h, input bit rdy,
                        input bit rq, input bit cl);
        int code;
        bit adv, ract, ld;
        enable = en; obj_hit = h; upd_ready = rdy; refresh_req = rq; clear = cl;
        #1;
        code = 0;
        for (int i = 0; i < 4; i++) if (h[i]) code = i + 1;
        adv  = en && !(m_valid && !rdy) && !cl;
        ract = (m_mode == 2) || (m_mode == 1 && m_pos == 0 && adv);
        chk("refresh_active", int'(refresh_active), int'(ract));
        if (upd_valid && rdy) begin
            xfers++; lx = upd_x; ly = upd_y; lc = upd_code;
        end
        if (cl) begin
            for (int i = 0; i < N; i++) m_frame[i] = 0;
            m_pos = 0; m_mode = 0; m_valid = 0; m_done = 0;
        end else begin
            m_done = adv && (m_pos == N - 1);
            ld = adv && ((code != m_frame[m_pos]) || ract);
            if (ld) begin
                m_valid = 1; m_rx = m_pos % W; m_ry = m_pos / W; m_rc = code;
            end else if (rdy) begin
                m_valid = 0;
            end
            if (m_mode == 0 && rq) m_mode = 1;
            else if (m_mode == 1 && adv && m_pos == 0) m_mode = 2;
            else if (m_mode == 2 && adv && m_pos == N - 1) m_mode = 0;
            if (adv) begin
                m_frame[m_pos] = code;
                m_pos = (m_pos + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        if (frame_done) fdones++;
        chk("cur_x", int'(cur_x), m_pos % W);
        chk("cur_y", int'(cur_y), m_pos / W);
        chk("upd_valid", int'(upd_valid), int'(m_valid));
        chk("frame_done", int'(frame_done), int'(m_done));
        if (m_valid) begin
            chk("upd_x", int'(upd_x), m_rx);
            chk("upd_y", int'(upd_y), m_ry);
            chk("upd_code", int'(upd_code), m_rc);
        end
    endtask

    task automatic run_to(input int target);
        int n = 0;
        do begin
            step(1'b1, 4'(pat[m_pos]), 1'b1, 1'b0, 1'b0);
            n++;
        end while (m_pos != target && n < 2 * N);
        if (n >= 2 * N) chk("run_to_timeout", n, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0, f0;
        nrst = 1'b0;
        enable = 0; obj_hit = 0; refresh_req = 0; clear = 0; upd_ready = 0;
        enable2 = 0; obj_hit2 = 0; refresh_req2 = 0; clear2 = 0; upd_ready2 = 0;
        xfers = 0; fdones = 0; lx = 0; ly = 0; lc = 0;
        m_reset();
        for (int i = 0; i < N; i++) pat[i] = 0;
        #3;
        chk("rst_cur_x", int'(cur_x), 0);
        chk("rst_cur_y", int'(cur_y), 0);
        chk("rst_upd_valid", int'(upd_valid), 0);
        chk("rst_upd_rec", int'({upd_x, upd_y, upd_code}), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_refresh", int'(refresh_active), 0);
        #19 nrst = 1'b1;
        @(posedge clk); #1;

        // empty first pass: no updates, one frame_done
        x0 = xfers; f0 = fdones;
        run_to(0);
        step(0, 0, 1, 0, 0);
        chk("empty_pass_updates", xfers - x0, 0);
        chk("empty_pass_done", fdones - f0, 1);

        // single hit 0101 at (3,2)
        pat[2*W+3] = 5;
        x0 = xfers;
        run_to(0);
        step(0, 0, 1, 0, 0);
        chk("single_hit_count", xfers - x0, 1);
        chk("single_hit_x", lx, 3);
        chk("single_hit_y", ly, 2);
        chk("single_hit_code", lc, 3);
        x0 = xfers;
        run_to(0);
        step(0, 0, 1, 0, 0);
        chk("repeat_pass_updates", xfers - x0, 0);

        // back-pressure with a pending record at cell 10
        pat[10] = 1;
        run_to(10);
        step(1, 4'(pat[10]), 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(1, 4'($urandom), 0, 0, 0);
            chk("stall_cursor", int'(cur_x), 11);
            chk("stall_rec_x", int'(upd_x), 10);
        end
        x0 = xfers;
        step(1, 4'(pat[11]), 1, 0, 0);
        chk("stall_accept", xfers - x0, 1);
        chk("resume_cursor", int'(cur_x), 12);
        run_to(0);

        // refresh requested mid-pass
        run_to(50);
        x0 = xfers;
        step(1, 4'(pat[50]), 1, 1, 0);
        run_to(0);
        chk("pend_no_updates", xfers - x0, 0);
        x0 = xfers;
        run_to(0);
        step(0, 0, 1, 0, 0);
        chk("refresh_updates", xfers - x0, N);
        chk("refresh_off", int'(refresh_active), 0);
        x0 = xfers;
        run_to(0);
        step(0, 0, 1, 0, 0);
        chk("post_refresh_updates", xfers - x0, 0);

        // clear at (7,5) with a record pending
        run_to(5*W+6);
        step(1, 4'b0010, 1, 0, 0);
        chk("pre_clear_valid", int'(upd_valid), 1);
        step(1, 4'(pat[5*W+7]), 0, 0, 1);
        chk("clear_valid", int'(upd_valid), 0);
        chk("clear_cursor", int'({cur_y, cur_x}), 0);
        step(1, 4'b0000, 1, 0, 0);
        step(1, 4'b0001, 1, 0, 0);
        x0 = xfers;
        step(0, 0, 1, 0, 0);
        chk("after_clear_count", xfers - x0, 1);
        chk("after_clear_rec", lx * 100 + ly * 10 + lc, 101);

        // randomized traffic with occasional refresh, clear and reset
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] h;
            h = ($urandom_range(0, 9) < 7) ? 4'b0 : 4'($urandom);
            if (c == 1500) begin
                nrst = 1'b0;
                #2;
                chk("midrst_cursor", int'({cur_y, cur_x}), 0);
                chk("midrst_valid", int'(upd_valid), 0);
                m_reset();
                #2 nrst = 1'b1;
            end
            step(($urandom_range(0, 9) < 8), h, ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 199) == 0), ($urandom_range(0, 299) == 0));
        end

        // 5x3 grid with 7 objects, every hit set
        enable2 = 1; obj_hit2 = 7'h7F; upd_ready2 = 1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            chk("g2_cur_x", int'(cur_x2), ((k + 1) % 15) % 5);
            chk("g2_cur_y", int'(cur_y2), ((k + 1) % 15) / 5);
            chk("g2_valid", int'(upd_valid2), int'(k < 15));
            chk("g2_done", int'(frame_done2), int'(k == 14));
            if (k < 15) begin
                chk("g2_code", int'(upd_code2), 7);
                chk("g2_upd_xy", int'(upd_x2) * 10 + int'(upd_y2), (k % 5) * 10 + k / 5);
            end
        end
        enable2 = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
